// File: rtl/fetch_queue_pkg.sv
// Shared constants and elaboration helpers for the instruction-fetch queue.
// The debug NOP shown on id_inst while the queue is empty lives here.
package fetch_queue_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] FQ_NOP = 32'h0000_0013;

    localparam int unsigned FQ_INST_W = 32;

    // Width of one queue entry: the instruction PC followed by the instruction word.
    function automatic int unsigned fq_entry_w(input int unsigned xlen);
        return xlen + FQ_INST_W;
    endfunction

    function automatic bit fq_is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH circular buffer holding prefetched {pc, inst} entries.
// Flush has priority over push and pop. Push into a full buffer is taken only when a pop frees a slot in the same cycle.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[head];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            // A simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// RV32 fetch stage: PC generator plus prefetch queue feeding decode over valid/ready.
// Define FETCH_BYPASS_EN to forward a fetch straight to decode when the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   halt,
    input  logic                   redir_valid,
    input  logic [XLEN-1:0]        redir_pc,
    output logic                   id_valid,
    input  logic                   id_ready,
    output logic [XLEN-1:0]        id_pc,
    output logic [31:0]            id_inst,
    output logic                   misalign,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int EW = fq_entry_w(XLEN);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [EW-1:0]   head_entry;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            q_pop;
    logic            q_push;
    logic            fire;
    logic            bypass;

    // Decode only pops real queue entries; a bypassed instruction never enters the queue.
    assign q_pop = id_ready && !q_empty;

    assign fire = !rst && !halt && !redir_valid && (!q_full || q_pop);

`ifdef FETCH_BYPASS_EN
    assign bypass = fire && q_empty && id_ready;
`else
    assign bypass = 1'b0;
`endif

    assign q_push = fire && !bypass;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redir_valid),
        .wdata ({pc, imem_rdata}),
        .rdata (head_entry),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            misalign <= redir_valid && (redir_pc[1:0] != 2'b00);
            if (redir_valid) begin
                pc <= {redir_pc[XLEN-1:2], 2'b00};
            end else if (fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    always_comb begin
        id_valid = !q_empty;
        id_pc    = head_entry[EW-1 -: XLEN];
        id_inst  = q_empty ? FQ_NOP : head_entry[31:0];
        if (bypass) begin
            id_valid = 1'b1;
            id_pc    = pc;
            id_inst  = imem_rdata;
        end
    end

    assign imem_addr = pc;
    assign occupancy = q_count;

endmodule
